// File: rtl/stepgen_mc_pkg.sv
// rtl/stepgen_mc_pkg.sv - shared types, command width and period clamp for the step generator
package stepgen_mc_pkg;

  localparam int CMD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HIGH  = 2'd2,
    ST_LOW   = 2'd3
  } ch_state_e;

  // |cmd| with the most negative value saturated, then raised to at least min_p
  function automatic logic [CMD_W-1:0] clamp_period(input logic [CMD_W-1:0] cmd,
                                                    input logic [CMD_W-1:0] min_p);
    logic [CMD_W-1:0] mag;
    if (cmd[CMD_W-1]) begin
      if (cmd == {1'b1, {(CMD_W-1){1'b0}}})
        mag = {1'b0, {(CMD_W-1){1'b1}}};
      else
        mag = ~cmd + CMD_W'(1);
    end else begin
      mag = cmd;
    end
    return (mag < min_p) ? min_p : mag;
  endfunction

endpackage

// File: rtl/stepgen_ch.sv
// rtl/stepgen_ch.sv - one step/dir channel FSM with optional position counter (STEPGEN_MC_FEEDBACK_EN)
module stepgen_ch
  import stepgen_mc_pkg::*;
#(
  parameter int PULSE_W   = 48,
  parameter int DIR_SETUP = 240
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CMD_W-1:0] freq_cmd,
  input  logic             fb_clr,
  output logic             stp,
  output logic             dir,
  output logic [CMD_W-1:0] feedback
);

  localparam logic [CMD_W-1:0] PW    = CMD_W'(PULSE_W);
  localparam logic [CMD_W-1:0] DS    = CMD_W'(DIR_SETUP);
  localparam logic [CMD_W-1:0] MIN_P = CMD_W'(PULSE_W + 1);

  ch_state_e        state_q, state_d;
  logic [CMD_W-1:0] cnt_q, cnt_d;
  logic [CMD_W-1:0] period_q, period_d;
  logic             dir_q, dir_d;
  logic             stp_q;
  logic             step_d;
  logic             cmd_nz, cmd_pos;

  assign cmd_nz  = |freq_cmd;
  assign cmd_pos = cmd_nz & ~freq_cmd[CMD_W-1];

  // Next-state logic: cnt holds the cycles remaining in the current state minus one
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    dir_d    = dir_q;
    step_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && cmd_nz) begin
          period_d = clamp_period(freq_cmd, MIN_P);
          if (cmd_pos != dir_q) begin
            dir_d   = cmd_pos;
            state_d = ST_SETUP;
            cnt_d   = DS - CMD_W'(1);
          end else begin
            state_d = ST_HIGH;
            cnt_d   = PW - CMD_W'(1);
            step_d  = 1'b1;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_HIGH;
          cnt_d   = PW - CMD_W'(1);
          step_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CMD_W'(1);
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          state_d = ST_LOW;
          cnt_d   = period_q - PW - CMD_W'(1);
        end else begin
          cnt_d = cnt_q - CMD_W'(1);
        end
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          // Only a same-sign command continues; a reversal goes back through IDLE and SETUP
          if (enable && cmd_nz && (cmd_pos == dir_q)) begin
            period_d = clamp_period(freq_cmd, MIN_P);
            state_d  = ST_HIGH;
            cnt_d    = PW - CMD_W'(1);
            step_d   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - CMD_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and the registered STP/DIR outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      dir_q    <= 1'b0;
      stp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      stp_q    <= (state_d == ST_HIGH);
    end
  end

  assign stp = stp_q;
  assign dir = dir_q;

`ifdef STEPGEN_MC_FEEDBACK_EN
  logic [CMD_W-1:0] fb_q;

  // Position counter: steps on the edge STP rises, clear has priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fb_q <= '0;
    else if (fb_clr)
      fb_q <= '0;
    else if (step_d)
      fb_q <= dir_d ? (fb_q + CMD_W'(1)) : (fb_q - CMD_W'(1));
  end

  assign feedback = fb_q;
`else
  logic unused_fb_sig;
  assign unused_fb_sig = fb_clr | step_d;
  assign feedback      = '0;
`endif

endmodule

// File: rtl/stepgen_mc.sv
// rtl/stepgen_mc.sv - multi-channel step/dir generator top (STEPGEN_MC_FEEDBACK_EN enables position feedback)
module stepgen_mc
  import stepgen_mc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int PULSE_W   = 48,
  parameter int DIR_SETUP = 240
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH*CMD_W-1:0] freq_cmd,
  input  logic                    fb_clr,
  output logic [NUM_CH-1:0]       STP,
  output logic [NUM_CH-1:0]       DIR,
  output logic [NUM_CH*CMD_W-1:0] feedback
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    stepgen_ch #(
      .PULSE_W  (PULSE_W),
      .DIR_SETUP(DIR_SETUP)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable[i]),
      .freq_cmd(freq_cmd[CMD_W*i +: CMD_W]),
      .fb_clr  (fb_clr),
      .stp     (STP[i]),
      .dir     (DIR[i]),
      .feedback(feedback[CMD_W*i +: CMD_W])
    );
  end

endmodule

// File: tb/tb_stepgen_mc.sv
// tb/tb_stepgen_mc.sv - randomized self-checking bench for stepgen_mc against an event-time model
module tb_stepgen_mc;

  localparam int NCH = 2;
  localparam int PW  = 4;
  localparam int DS  = 8;
`ifdef STEPGEN_MC_FEEDBACK_EN
  localparam bit FB_ON = 1'b1;
`else
  localparam bit FB_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    enable = '0;
  logic [NCH*32-1:0] freq_cmd = '0;
  logic              fb_clr = 1'b0;
  logic [NCH-1:0]    STP;
  logic [NCH-1:0]    DIR;
  logic [NCH*32-1:0] feedback;

  stepgen_mc #(.NUM_CH(NCH), .PULSE_W(PW), .DIR_SETUP(DS)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .freq_cmd(freq_cmd),
    .fb_clr(fb_clr), .STP(STP), .DIR(DIR), .feedback(feedback)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: each running channel is described by the edge of its last rising STP and its period
  bit          m_busy [NCH];
  bit          m_dir  [NCH];
  bit          m_stp  [NCH];
  longint      m_rise [NCH];
  longint      m_p    [NCH];
  logic [31:0] m_fb   [NCH];
  longint      n = 0;

  longint rises0[$];
  longint rises1[$];
  bit     prev_stp[NCH];
  bit     prev_dir0;
  longint dir_fall0;
  int     hi_cnt0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, n);
    end
  endtask

  function automatic longint clampp(input logic [31:0] c);
    longint v;
    v = longint'($signed(c));
    if (v < 0) v = -v;
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < PW + 1) v = PW + 1;
    return v;
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_busy[c] = 1'b0; m_dir[c] = 1'b0; m_stp[c] = 1'b0;
      m_rise[c] = 0; m_p[c] = 0; m_fb[c] = '0;
    end
  endfunction

  function automatic void model_step();
    logic [31:0] c;
    bit nz, pos;
    n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int ch = 0; ch < NCH; ch++) begin
      c   = freq_cmd[32*ch +: 32];
      nz  = (c != 0);
      pos = ($signed(c) > 0);
      if (m_busy[ch] && n == m_rise[ch] + m_p[ch]) begin
        if (enable[ch] && nz && pos == m_dir[ch]) begin
          m_rise[ch] = n;
          m_p[ch]    = clampp(c);
        end else begin
          m_busy[ch] = 1'b0;
        end
      end else if (!m_busy[ch]) begin
        if (enable[ch] && nz) begin
          m_p[ch] = clampp(c);
          if (pos != m_dir[ch]) begin
            m_dir[ch]  = pos;
            m_rise[ch] = n + DS;
          end else begin
            m_rise[ch] = n;
          end
          m_busy[ch] = 1'b1;
        end
      end
      m_stp[ch] = m_busy[ch] && n >= m_rise[ch] && n < m_rise[ch] + PW;
      if (fb_clr)
        m_fb[ch] = '0;
      else if (m_busy[ch] && n == m_rise[ch])
        m_fb[ch] = m_dir[ch] ? m_fb[ch] + 32'd1 : m_fb[ch] - 32'd1;
    end
  endfunction

  function automatic longint exp_fb(input int ch);
    return FB_ON ? longint'(m_fb[ch]) : 64'd0;
  endfunction

  // One clock: advance the model on the edge, compare every output 1 unit later
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    for (int ch = 0; ch < NCH; ch++) begin
      check($sformatf("stp%0d", ch), STP[ch], m_stp[ch]);
      check($sformatf("dir%0d", ch), DIR[ch], m_dir[ch]);
      check($sformatf("feedback%0d", ch), longint'(feedback[32*ch +: 32]), exp_fb(ch));
    end
    if (STP[0] && !prev_stp[0]) rises0.push_back(n);
    if (STP[1] && !prev_stp[1]) rises1.push_back(n);
    if (prev_dir0 && !DIR[0]) dir_fall0 = n;
    if (STP[0]) hi_cnt0++;
    prev_stp[0] = STP[0];
    prev_stp[1] = STP[1];
    prev_dir0   = DIR[0];
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stp"}, longint'(STP), 0);
    check({tag, "_dir"}, longint'(DIR), 0);
    check({tag, "_fb0"}, longint'(feedback[31:0]), 0);
    check({tag, "_fb1"}, longint'(feedback[63:32]), 0);
  endtask

  // Asynchronous reset pulse taken between clock edges
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero(tag);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rand_cmd();
    int m;
    if ($urandom_range(0, 9) == 0) return 32'd0;
    m = int'($urandom_range(1, 40));
    return ($urandom_range(0, 1) == 1) ? 32'(-m) : 32'(m);
  endfunction

  longint e0, eb, ec, ed;
  bit     got;

  initial begin
    model_reset();
    prev_stp[0] = 1'b0; prev_stp[1] = 1'b0; prev_dir0 = 1'b0;
    dir_fall0 = -1; hi_cnt0 = 0;

    // Model pins
    check("clamp_min", clampp(32'd2), 5);
    check("clamp_sat", clampp(32'h80000000), 2147483647);
    check("clamp_neg", clampp(32'hFFFFFFEC), 20);

    #2;
    check_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // Constant commands: ch0 +20 (through SETUP), ch1 -12 (straight to HIGH)
    enable = 2'b11;
    freq_cmd[31:0]  = 32'd20;
    freq_cmd[63:32] = 32'hFFFFFFF4;
    rises0.delete(); rises1.delete(); hi_cnt0 = 0;
    e0 = n + 1;
    repeat (60) tick();
    check("a_rises0", rises0.size(), 3);
    if (rises0.size() >= 3) begin
      check("a_first0", rises0[0] - e0, 8);
      check("a_per0a", rises0[1] - rises0[0], 20);
      check("a_per0b", rises0[2] - rises0[1], 20);
    end
    check("a_high0", hi_cnt0, 12);
    check("a_dir0", DIR[0], 1);
    check("a_fb0", longint'(feedback[31:0]), FB_ON ? 64'd3 : 64'd0);
    check("a_rises1", rises1.size(), 5);
    if (rises1.size() >= 1) check("a_first1", rises1[0] - e0, 0);
    check("a_fb1", longint'(feedback[63:32]), FB_ON ? 64'h00000000FFFFFFFB : 64'd0);

    // Reversal mid-LOW: period completes, IDLE, DIR falls, rise DIR_SETUP later
    freq_cmd[31:0] = 32'hFFFFFFEC;
    eb = n;
    rises0.delete(); dir_fall0 = -1;
    repeat (40) tick();
    check("b_dirfall", dir_fall0 - eb, 10);
    check("b_rises0", rises0.size(), 2);
    if (rises0.size() >= 2) begin
      check("b_setup", rises0[0] - dir_fall0, 8);
      check("b_per", rises0[1] - rises0[0], 20);
    end
    check("b_dir0", DIR[0], 0);
    check("b_fb0", longint'(feedback[31:0]), FB_ON ? 64'd1 : 64'd0);

    // Short command clamps to PULSE_W+1
    freq_cmd[31:0] = 32'd2;
    ec = n;
    rises0.delete();
    repeat (40) tick();
    check("c_rises0", rises0.size(), 3);
    if (rises0.size() >= 2) begin
      check("c_first", rises0[0] - ec, 27);
      check("c_per", rises0[1] - rises0[0], 5);
    end
    check("c_dir0", DIR[0], 1);

    // Most negative command: saturated period, negative direction
    freq_cmd[31:0] = 32'h80000000;
    ed = n;
    rises0.delete();
    repeat (40) tick();
    check("d_rises0", rises0.size(), 1);
    if (rises0.size() >= 1) check("d_first", rises0[0] - ed, 11);
    check("d_dir0", DIR[0], 0);

    // Reset during HIGH
    freq_cmd[31:0] = 32'd20;
    reset_pulse("r1");
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      tick();
      if (STP[0]) got = 1'b1;
    end
    check("r_wait_high", got, 1);
    reset_pulse("r2");
    rises0.delete(); rises1.delete();
    tick();
    check("r_ch1_first", STP[1], 1);

    // fb_clr on the edge of the 8th rise, with feedback0 = 7
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (m_busy[0] && m_fb[0] == 32'd7 && n + 1 == m_rise[0] + m_p[0]) got = 1'b1;
      else tick();
    end
    check("e_wait_fb7", got, 1);
    fb_clr = 1'b1;
    tick();
    fb_clr = 1'b0;
    check("e_stp0", STP[0], 1);
    check("e_fb0", longint'(feedback[31:0]), 0);
    check("e_fb1", longint'(feedback[63:32]), 0);
    if (rises1.size() >= 2) check("r_ch1_per", rises1[1] - rises1[0], 12);
    else check("r_ch1_rises", rises1.size(), 2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 39) == 0) freq_cmd[32*ch +: 32] = rand_cmd();
        if ($urandom_range(0, 59) == 0) enable[ch] = ~enable[ch];
      end
      fb_clr = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 499) == 0) begin
        fb_clr = 1'b0;
        reset_pulse("rand_rst");
      end else begin
        tick();
      end
    end
    fb_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stepgen_mc.md
STEPGEN_MC -- requirements
Module: stepgen_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent step/dir channels (1..16).
REQ-002 SHALL have parameter PULSE_W, default 48: STP high time in clk cycles (>=1).
REQ-003 SHALL have parameter DIR_SETUP, default 240: clk cycles from a DIR change to the next STP rising edge (>=1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port enable, input, NUM_CH: per-channel run enable.
REQ-007 SHALL have port freq_cmd, input, NUM_CH*32: per-channel signed period command, channel i at bits [32i+31:32i]; the sign selects direction, |value| is the step period in cycles, and 0 means stop.
REQ-008 SHALL have port fb_clr, input, 1: synchronous clear of all position counters.
REQ-009 SHALL have port STP, output, NUM_CH: step pulses.
REQ-010 SHALL have port DIR, output, NUM_CH: direction, 1 when the command is positive.
REQ-011 SHALL have port feedback, output, NUM_CH*32: per-channel signed step position, using the same packing as freq_cmd.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, SETUP, HIGH and LOW; STP SHALL be 1 only in HIGH.
REQ-013 In IDLE, when enable=1 and cmd!=0, the channel SHALL latch period P=|cmd| and new direction nd=(cmd>0).
- If nd!=DIR: update DIR and go to SETUP.
- Otherwise: go to HIGH.
REQ-014 SETUP SHALL last exactly DIR_SETUP cycles and then go to HIGH.
REQ-015 HIGH SHALL last exactly PULSE_W cycles and then go to LOW.
REQ-016 LOW SHALL last P-PULSE_W cycles. At its last cycle the channel SHALL re-sample enable and cmd:
- enable=1, cmd!=0 and the sign is unchanged: latch the new P and go to HIGH.
- Otherwise: go to IDLE.
REQ-017 With a constant command, consecutive STP rising edges SHALL be exactly P cycles apart.
REQ-018 P SHALL be clamped to a minimum of PULSE_W+1, and |-2^31| SHALL saturate to 2^31-1.
REQ-019 A command change mid-period SHALL take effect only at the next sample point, never truncating HIGH or LOW.
REQ-020 enable falling SHALL let the current HIGH/LOW complete, after which the channel goes to IDLE.
REQ-021 A reversal SHALL always pass through IDLE and SETUP, so DIR never changes within DIR_SETUP cycles before a rising edge or while STP=1.
REQ-022 feedback SHALL change by +1 (DIR=1) or -1 (DIR=0) in the cycle STP rises, wrapping in two's complement.
REQ-023 When fb_clr=1, all feedback registers SHALL become 0 on the next edge; fb_clr wins over a coincident step count.
REQ-024 Outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-025 rst_n=0 SHALL immediately force every channel to IDLE, STP=0, DIR=0, feedback=0 and all internal counters to 0, including mid-pulse.
REQ-026 After rst_n rises, the first STP edge SHALL follow SETUP if the command is positive, and go directly to HIGH if it is negative.

Configuration
REQ-027 With the macro STEPGEN_MC_FEEDBACK_EN defined, the position counters and fb_clr behaviour SHALL be implemented as in REQ-022/023.
REQ-028 Without STEPGEN_MC_FEEDBACK_EN:
- feedback SHALL be constant 0 and fb_clr ignored.
- No counter registers SHALL be synthesised.
- STP and DIR timing SHALL be unchanged.

Structure
REQ-029 A shared package SHALL hold the channel FSM state enum, CMD_W=32 and a period-clamp/abs helper function.
REQ-030 The per-channel logic SHALL be a sub-module stepgen_ch, instantiated NUM_CH times with a generate loop; stepgen_mc SHALL only pack and unpack the vectors.

Verification
REQ-031 NUM_CH=2, PULSE_W=4, DIR_SETUP=8, cmd0=+20, enable0=1 -> STP0 rising edges every 20 cycles, high 4 cycles, DIR0=1, feedback0 +1 per edge.
REQ-032 cmd0 changes +20 -> -20 mid-LOW -> the current period completes, STP stays low, DIR0=0, the next rising edge is exactly 8 cycles after DIR0 falls, and feedback0 then decrements.
REQ-033 cmd=+2 (below PULSE_W+1) and cmd=32'h80000000 -> period clamped to 5; magnitude saturates with no overflow and DIR=0.
REQ-034 rst_n pulsed low during HIGH -> STP, DIR and feedback go to 0 asynchronously, and channel 1 is unaffected in timing after release.
REQ-035 fb_clr asserted on the same cycle as a step rising edge with feedback0=7 -> feedback0=0 next cycle; the feedback1 count is also 0.
REQ-036 Build without STEPGEN_MC_FEEDBACK_EN -> feedback stays 0 under all of the above, and STP/DIR waveforms are identical to the enabled build.
